// File: rtl/btn_event_capture.sv
// Button/switch front end: 2-FF sync, counter debounce and sticky press flags cleared by a port read.
// Optional per-bit auto-repeat while a button is held is enabled with `define BTN_AUTOREPEAT_EN.
module btn_event_capture #(
  parameter int          N_BTN           = 8,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          DB_W            = 20,
  parameter logic [7:0]  PORT_ADDR       = 8'hFE,
  parameter int          REPEAT_DELAY    = 12500000,
  parameter int          REPEAT_RATE     = 5000000,
  parameter int          RPT_W           = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_raw,
  input  logic [7:0]        port_id,
  input  logic              read_strobe,
  output logic [N_BTN-1:0]  level_out,
  output logic [N_BTN-1:0]  event_out,
  output logic              event_any
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations whose counters cannot reach their terminal count.
  if (DEBOUNCE_CYCLES < 1 || (DEBOUNCE_CYCLES >> DB_W) != 0) begin : g_bad_debounce_cfg
    $error("btn_event_capture: DEBOUNCE_CYCLES must be >= 1 and fit in DB_W bits");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 || RPT_W < 1 ||
      (REPEAT_DELAY >> RPT_W) != 0 || (REPEAT_RATE >> RPT_W) != 0) begin : g_bad_repeat_cfg
    $error("btn_event_capture: REPEAT_DELAY/REPEAT_RATE must be >= 1 and fit in RPT_W bits");
  end

  // --------------------------------------------------------------------------
  // Synchroniser, debounced level and its one-cycle delayed copy
  // --------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] level_dly_q;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] rpt_tick;
  logic [N_BTN-1:0] set_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign rise    = level_q & ~level_dly_q;
  assign set_vec = rise | rpt_tick;

  // --------------------------------------------------------------------------
  // Per-bit debounce: a new level is accepted only after it has been seen
  // on the synchronised input for DEBOUNCE_CYCLES consecutive clocks.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_debounce
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            lvl_bit_d;

    always_comb begin
      db_cnt_d  = '0;
      lvl_bit_d = level_q[gi];
      if (sync2_q[gi] != level_q[gi]) begin
        if (db_cnt_q == DB_LAST) begin
          lvl_bit_d = sync2_q[gi];
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_d;
      end
    end

    assign level_d[gi] = lvl_bit_d;
  end

  // --------------------------------------------------------------------------
  // Auto-repeat: while a bit stays pressed, emit extra set pulses after
  // REPEAT_DELAY clocks and then every REPEAT_RATE clocks.
  // --------------------------------------------------------------------------
`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RR_LAST = RPT_W'(REPEAT_RATE - 1);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_repeat
    rpt_state_e       state_q;
    rpt_state_e       state_d;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_d;
    logic             tick;

    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      tick      = 1'b0;
      // A released button always drops back to idle, whatever the state.
      if (!level_q[gi]) begin
        state_d   = RPT_IDLE;
        rpt_cnt_d = '0;
      end else begin
        case (state_q)
          RPT_IDLE: begin
            if (rise[gi]) begin
              state_d   = RPT_DELAY;
              rpt_cnt_d = '0;
            end
          end
          RPT_DELAY: begin
            if (rpt_cnt_q == RD_LAST) begin
              tick      = 1'b1;
              state_d   = RPT_REPEAT;
              rpt_cnt_d = '0;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (rpt_cnt_q == RR_LAST) begin
              tick      = 1'b1;
              rpt_cnt_d = '0;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
          end
          default: begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= RPT_IDLE;
        rpt_cnt_q <= '0;
      end else begin
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
      end
    end

    assign rpt_tick[gi] = tick;
  end
`else
  assign rpt_tick = '0;
`endif

  // --------------------------------------------------------------------------
  // Sticky event flags. A read of PORT_ADDR clears everything, but a press
  // landing on the clearing edge survives so the next read still sees it.
  // --------------------------------------------------------------------------
  logic [N_BTN-1:0] event_q;
  logic [N_BTN-1:0] event_d;
  logic             event_any_q;
  logic             clr;

  assign clr = read_strobe && (port_id == PORT_ADDR);

  always_comb begin
    event_d = event_q;
    if (clr) begin
      event_d = '0;
    end
    event_d = event_d | set_vec;
  end

  // event_any is taken from the next-state flags so it lines up with event_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_q     <= '0;
      event_any_q <= 1'b0;
    end else begin
      event_q     <= event_d;
      event_any_q <= |event_d;
    end
  end

  assign level_out = level_q;
  assign event_out = event_q;
  assign event_any = event_any_q;

endmodule
